// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if
//   Bundles the byte-stream input and the decoded outputs of uart_cmd_decoder.
//   master : byte source / consumer of decoded state (top level, bench)
//   slave  : the decoder itself
//   Signals:
//     rx_data[7:0]     received byte, meaningful only while rx_valid=1
//     rx_valid         single-cycle strobe per received byte
//     cat_status[7:0]  cat mask, 1 = alive
//     key_out          last committed key, first received byte in the MSBs
//     key_valid        one-cycle pulse when key_out changes
//     cmd_ok           one-cycle pulse per committed frame
//     cmd_error        one-cycle pulse per rejected frame
//     err_code[1:0]    cause of the last error (1 cmd, 2 arg, 3 term/timeout)
//     busy             decoder is inside a frame
interface uart_cmd_decoder_if #(
    parameter int KEY_BYTES = 16
);
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic [7:0]             cat_status;
    logic [8*KEY_BYTES-1:0] key_out;
    logic                   key_valid;
    logic                   cmd_ok;
    logic                   cmd_error;
    logic [1:0]             err_code;
    logic                   busy;

    modport master (
        output rx_data, rx_valid,
        input  cat_status, key_out, key_valid, cmd_ok, cmd_error, err_code, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output cat_status, key_out, key_valid, cmd_ok, cmd_error, err_code, busy
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
//   Parses framed commands <cmd><payload><cmd> from the UART byte stream.
//     'A' <arg> 'A' : arg 0x41+n clears cat_status[n], arg 0x60 restores all cats
//     'B' <KEY_BYTES bytes> 'B' : commits a new key_out
//   A frame left idle for TIMEOUT_CYCLES clocks between bytes is dropped.
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    uart_cmd_decoder_if.slave (byte input, decoded outputs)
module uart_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 5_167_000,
    parameter int KEY_BYTES      = 16
) (
    input  logic                clk,
    input  logic                reset,
    uart_cmd_decoder_if.slave   bus
);
    localparam int KW = 8 * KEY_BYTES;
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int IW = $clog2(KEY_BYTES + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(KEY_BYTES - 1);

    localparam logic [7:0] CH_A  = 8'h41;
    localparam logic [7:0] CH_B  = 8'h42;
    localparam logic [7:0] CH_H  = 8'h48;
    localparam logic [7:0] CH_BQ = 8'h60;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {S_IDLE, S_ARG, S_KEY, S_END} state_e;

    state_e          state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      arg_q, arg_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [KW-1:0]   stage_q, stage_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      cat_q, cat_d;
    logic [KW-1:0]   key_q, key_d;
    logic            kv_q, kv_d;
    logic            ok_q, ok_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;

    logic            timeout;
    logic            arg_ok;
    logic [2:0]      cat_bit;

    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout = (state_q != S_IDLE) && !bus.rx_valid && (cnt_q == CNT_LAST);
    assign arg_ok  = ((bus.rx_data >= CH_A) && (bus.rx_data <= CH_H)) || (bus.rx_data == CH_BQ);
    // 0x41..0x48 have low bits 1..7,0 so subtracting one maps them onto 0..7.
    assign cat_bit = arg_q[2:0] - 3'd1;

    // State register and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            arg_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            cnt_q   <= '0;
            cat_q   <= 8'hFF;
            key_q   <= '0;
            kv_q    <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            cat_q   <= cat_d;
            key_q   <= key_d;
            kv_q    <= kv_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = S_IDLE;
        end else if (bus.rx_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.rx_data == CH_A)      state_d = S_ARG;
                    else if (bus.rx_data == CH_B) state_d = S_KEY;
                end
                S_ARG:  state_d = arg_ok ? S_END : S_IDLE;
                S_KEY:  if (idx_q == IDX_LAST) state_d = S_END;
                S_END:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath / output next values
    always_comb begin
        cmd_d   = cmd_q;
        arg_d   = arg_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        cat_d   = cat_q;
        key_d   = key_q;
        kv_d    = 1'b0;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        cnt_d   = (bus.rx_valid || (state_q == S_IDLE)) ? '0 : cnt_q + 1'b1;

        if (timeout) begin
            err_d   = 1'b1;
            code_d  = 2'd3;
            idx_d   = '0;
            stage_d = '0;
        end else if (bus.rx_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.rx_data == CH_A) begin
                        cmd_d = bus.rx_data;
                    end else if (bus.rx_data == CH_B) begin
                        cmd_d   = bus.rx_data;
                        idx_d   = '0;
                        stage_d = '0;
                    end else if ((bus.rx_data != CH_LF) && (bus.rx_data != CH_CR)) begin
                        err_d  = 1'b1;
                        code_d = 2'd1;
                    end
                end
                S_ARG: begin
                    if (arg_ok) begin
                        arg_d = bus.rx_data;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'd2;
                    end
                end
                S_KEY: begin
                    // Shift in from the LSB end: first byte ends up in the MSBs.
                    stage_d = (stage_q << 8) | KW'(bus.rx_data);
                    idx_d   = idx_q + 1'b1;
                end
                S_END: begin
                    if (bus.rx_data == cmd_q) begin
                        ok_d = 1'b1;
                        if (cmd_q == CH_A) begin
                            if (arg_q == CH_BQ) cat_d = 8'hFF;
                            else                cat_d[cat_bit] = 1'b0;
                        end else begin
                            key_d = stage_q;
                            kv_d  = 1'b1;
                        end
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'd3;
                    end
                    idx_d   = '0;
                    stage_d = '0;
                end
                default: ;
            endcase
        end
    end

    // Output assignments (all driven from registers)
    assign bus.cat_status = cat_q;
    assign bus.key_out    = key_q;
    assign bus.key_valid  = kv_q;
    assign bus.cmd_ok     = ok_q;
    assign bus.cmd_error  = err_q;
    assign bus.err_code   = code_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_cmd_decoder.sv
module tb_uart_cmd_decoder;
    localparam int TO = 8;
    localparam int KB = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_decoder_if #(.KEY_BYTES(KB)) bif ();

    uart_cmd_decoder #(.TIMEOUT_CYCLES(TO), .KEY_BYTES(KB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int errors = 0;
    int checks = 0;
    bit run = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Frame-level model: the frame is the list of bytes received so far.
    logic [7:0]   fr[$];
    int           quiet;
    logic [7:0]   m_cat;
    logic [127:0] m_key;
    logic         m_kv, m_ok, m_err;
    logic [1:0]   m_code;

    function automatic int frame_len(input logic [7:0] c);
        return (c == 8'h41) ? 3 : KB + 2;
    endfunction

    task automatic m_reject(input logic [1:0] c);
        m_err  = 1'b1;
        m_code = c;
        fr.delete();
        quiet  = 0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        if (fr.size() == 0) begin
            if (b == 8'h41 || b == 8'h42) fr.push_back(b);
            else if (b != 8'h0A && b != 8'h0D) m_reject(2'd1);
        end else if (fr.size() == frame_len(fr[0]) - 1) begin
            if (b == fr[0]) begin
                m_ok = 1'b1;
                if (fr[0] == 8'h41) begin
                    if (fr[1] == 8'h60) m_cat = 8'hFF;
                    else m_cat[int'(fr[1]) - 'h41] = 1'b0;
                end else begin
                    for (int i = 1; i <= KB; i++) m_key = {m_key[119:0], fr[i]};
                    m_kv = 1'b1;
                end
                fr.delete();
            end else begin
                m_reject(2'd3);
            end
        end else if (fr[0] == 8'h41) begin
            if ((b >= 8'h41 && b <= 8'h48) || b == 8'h60) fr.push_back(b);
            else m_reject(2'd2);
        end else begin
            fr.push_back(b);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fr.delete();
            quiet = 0;
            m_cat = 8'hFF; m_key = '0; m_kv = 0; m_ok = 0; m_err = 0; m_code = 0;
        end else begin
            m_kv = 0; m_ok = 0; m_err = 0;
            if (bif.rx_valid) begin
                quiet = 0;
                m_byte(bif.rx_data);
            end else if (fr.size() != 0) begin
                quiet++;
                if (quiet == TO) m_reject(2'd3);
            end
        end
    end

    always @(negedge clk) begin
        if (run && !reset) begin
            chk("cat_status", bif.cat_status, m_cat);
            chk("key_out",    bif.key_out,    m_key);
            chk("key_valid",  bif.key_valid,  m_kv);
            chk("cmd_ok",     bif.cmd_ok,     m_ok);
            chk("cmd_error",  bif.cmd_error,  m_err);
            chk("err_code",   bif.err_code,   m_code);
            chk("busy",       bif.busy,       fr.size() != 0);
        end
    end

    // Each call occupies exactly one cycle; consecutive calls are back-to-back.
    task automatic send(input logic [7:0] b);
        bif.rx_valid = 1'b1;
        bif.rx_data  = b;
        @(posedge clk); #1;
        bif.rx_valid = 1'b0;
        bif.rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] KEY_SEQ = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        bif.rx_valid = 1'b0;
        bif.rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_cat",  bif.cat_status, 8'hFF);
        chk("rst_key",  bif.key_out, '0);
        chk("rst_busy", bif.busy, 1'b0);
        chk("rst_code", bif.err_code, 2'd0);
        run = 1'b1;

        // clear cat 2
        send(8'h41); chk("a_busy1", bif.busy, 1'b1);
        send(8'h43);
        send(8'h41);
        chk("a_cat", bif.cat_status, 8'hFB);
        chk("a_ok", bif.cmd_ok, 1'b1);
        chk("a_busy0", bif.busy, 1'b0);
        idle(1); chk("a_ok_pulse", bif.cmd_ok, 1'b0);

        // restore all
        send(8'h41); send(8'h60); send(8'h41);
        chk("bq_cat", bif.cat_status, 8'hFF);

        // bad argument, trailing 'A' opens a new frame that then times out
        send(8'h41); send(8'h49);
        chk("arg_err", bif.cmd_error, 1'b1);
        chk("arg_code", bif.err_code, 2'd2);
        send(8'h41);
        chk("arg_busy", bif.busy, 1'b1);
        idle(TO + 2);

        // key frame, back-to-back
        send(8'h42);
        for (int i = 0; i < KB; i++) send(8'(i));
        send(8'h42);
        chk("key_val", bif.key_out, KEY_SEQ);
        chk("key_kv", bif.key_valid, 1'b1);
        idle(1); chk("key_kv_pulse", bif.key_valid, 1'b0);

        // bad terminator leaves key alone
        send(8'h42);
        for (int i = 0; i < KB; i++) send(8'(8'hA0 + i));
        send(8'h41);
        chk("term_err", bif.cmd_error, 1'b1);
        chk("term_code", bif.err_code, 2'd3);
        chk("term_key", bif.key_out, KEY_SEQ);
        chk("term_kv", bif.key_valid, 1'b0);

        // CR/LF ignored, unknown command rejected
        send(8'h0D); chk("cr_err", bif.cmd_error, 1'b0);
        send(8'h0A); chk("lf_err", bif.cmd_error, 1'b0);
        send(8'h5A);
        chk("unk_err", bif.cmd_error, 1'b1);
        chk("unk_code", bif.err_code, 2'd1);

        // timeout fires on the 8th silent cycle
        send(8'h42); send(8'h01); send(8'h02); send(8'h03);
        idle(TO - 1);
        chk("to_pre_err", bif.cmd_error, 1'b0);
        chk("to_pre_busy", bif.busy, 1'b1);
        idle(1);
        chk("to_err", bif.cmd_error, 1'b1);
        chk("to_code", bif.err_code, 2'd3);
        chk("to_busy", bif.busy, 1'b0);

        // byte on the expiry cycle wins
        send(8'h42); send(8'h01); send(8'h02); send(8'h03);
        idle(TO - 1);
        send(8'h04);
        chk("exp_err", bif.cmd_error, 1'b0);
        chk("exp_busy", bif.busy, 1'b1);
        idle(1); chk("exp_err2", bif.cmd_error, 1'b0);
        idle(TO + 2);

        // clear cat 0 twice, then cat 7
        send(8'h41); send(8'h41); send(8'h41);
        send(8'h41); send(8'h41); send(8'h41);
        chk("dup_ok", bif.cmd_ok, 1'b1);
        chk("dup_cat", bif.cat_status, 8'hFE);
        send(8'h41); send(8'h48); send(8'h41);
        chk("h_cat", bif.cat_status, 8'h7E);

        // asynchronous reset in the middle of a key frame
        send(8'h42);
        for (int i = 0; i < 5; i++) send(8'(i));
        #2 reset = 1'b1;
        #1;
        chk("arst_cat", bif.cat_status, 8'hFF);
        chk("arst_key", bif.key_out, '0);
        chk("arst_busy", bif.busy, 1'b0);
        chk("arst_code", bif.err_code, 2'd0);
        @(posedge clk); #1 reset = 1'b0;
        idle(2);
        send(8'h41); send(8'h44); send(8'h41);
        chk("post_cat", bif.cat_status, 8'hF7);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
